// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone timeout bridge.
//   state_e          FSM state encoding (IDLE / BUSY / RESP)
//   TO_DATA_DEFAULT  read data returned when a transfer is forcibly terminated
//   cnt_width()      width of a counter that must hold 0..terminal
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] TO_DATA_DEFAULT = 32'hDEADBEEF;

  // Bits needed to represent the value 'terminal' (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned terminal);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) <= 64'(terminal))) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_timeout_bridge_if.sv
// Wishbone classic bus bundle used on both sides of the bridge.
//   cyc/stb/we/sel/adr/dat_w : master -> slave request
//   dat_r/ack                : slave -> master response
// Modports: master (drives the request), slave (drives the response).
interface wb_timeout_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  localparam int unsigned SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter for the bridge's downstream wait.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (takes priority over en)
//   en       : advance count by one, saturating at TERMINAL
//   tc_c     : combinational; high while enabled on the last allowed cycle
//              (count == TERMINAL-1)
module wb_timeout_counter #(
  parameter int unsigned TERMINAL = 255,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CW-1:0] count;

  // Saturating counter; never wraps back to zero on its own.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != CW'(TERMINAL))) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = en && (count == CW'(TERMINAL - 1));

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone classic stage between the management-core master and
// the user-project fabric. One transfer in flight; if the fabric does not ack
// within TIMEOUT_CYCLES strobe cycles the transfer is terminated upstream with
// ack + TO_DATA and timeout_irq_o pulses for one cycle.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs                : upstream bus (bridge is the slave)
//   m                  : downstream bus (bridge is the master)
//   timeout_irq_o      : one-cycle pulse, coincident with the timeout ack
//   to_count_o         : saturating timeout count      (WB_TIMEOUT_STATS_EN)
//   to_addr_o          : address of the latest timeout (WB_TIMEOUT_STATS_EN)
// Build option: define WB_TIMEOUT_STATS_EN to add the timeout statistics.
module wb_timeout_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter int unsigned   TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0] TO_DATA        = DW'(TO_DATA_DEFAULT)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_timeout_bridge_if.slave  wbs,
  wb_timeout_bridge_if.master m,
  output logic               timeout_irq_o
`ifdef WB_TIMEOUT_STATS_EN
  ,
  output logic [15:0]        to_count_o,
  output logic [AW-1:0]      to_addr_o
`endif
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          irq_q, irq_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc_c;

  wb_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES),
    .CW       (CW)
  ) u_counter (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (cnt_tc_c)
  );

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    irq_d   = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbs.cyc && wbs.stb) begin
          state_d = BUSY;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = wbs.we;
          sel_d   = wbs.sel;
          adr_d   = wbs.adr;
          wdat_d  = wbs.dat_w;
        end
      end

      BUSY: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        // An abandoned cycle must never be acked, so abort outranks ack.
        if (!wbs.cyc) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
        end else if (m.ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          rdat_d  = m.dat_r;
        end else if (cnt_tc_c) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          irq_d   = 1'b1;
          rdat_d  = TO_DATA;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  assign m.cyc         = cyc_q;
  assign m.stb         = stb_q;
  assign m.we          = we_q;
  assign m.sel         = sel_q;
  assign m.adr         = adr_q;
  assign m.dat_w       = wdat_q;
  assign wbs.ack       = ack_q;
  assign wbs.dat_r     = rdat_q;
  assign timeout_irq_o = irq_q;

`ifdef WB_TIMEOUT_STATS_EN
  // Timeout statistics, updated on the same edge that raises the IRQ.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_count_o <= '0;
      to_addr_o  <= '0;
    end else if (irq_d) begin
      if (to_count_o != 16'hFFFF) begin
        to_count_o <= to_count_o + 16'd1;
      end
      to_addr_o <= adr_q;
    end
  end
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed self-checking bench for wb_timeout_bridge (TIMEOUT_CYCLES = 16).
// Inputs are driven and outputs observed on the falling clock edge.
module tb_wb_timeout_bridge;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic timeout_irq;
`ifdef WB_TIMEOUT_STATS_EN
  logic [15:0] to_count;
  logic [31:0] to_addr;
`endif

  wb_timeout_bridge_if #(.AW(32), .DW(32)) up ();
  wb_timeout_bridge_if #(.AW(32), .DW(32)) dn ();

  always #5 clk = ~clk;

  wb_timeout_bridge #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (TO),
    .TO_DATA        (32'hDEADBEEF)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs           (up),
    .m             (dn),
    .timeout_irq_o (timeout_irq)
`ifdef WB_TIMEOUT_STATS_EN
    ,
    .to_count_o    (to_count),
    .to_addr_o     (to_addr)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observations from the most recent run_txn.
  int          r_ack_n, r_first_ack, r_irq_n, r_stb_n, r_stb_first, r_stb_last;
  logic        r_irq_at_ack, r_cyc_after_abort, r_we1;
  logic [31:0] r_rdata, r_adr1, r_wdat1;
  logic [3:0]  r_sel1;

  // Issue one transfer at cycle 0; slave acks at ack_cyc (0 = never);
  // master drops cyc at abort_cyc (0 = never) or the cycle after its ack.
  task automatic run_txn(input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] wdat,
                         input int ack_cyc, input logic [31:0] sdata,
                         input int abort_cyc, input int ncyc);
    logic done;
    r_ack_n = 0; r_first_ack = -1; r_irq_n = 0; r_stb_n = 0;
    r_stb_first = -1; r_stb_last = -1; r_irq_at_ack = 1'b0;
    r_rdata = '0; r_cyc_after_abort = 1'b1;
    done = 1'b0;
    @(negedge clk);
    up.cyc = 1'b1; up.stb = 1'b1; up.we = we; up.sel = sel;
    up.adr = adr; up.dat_w = wdat;
    dn.ack = 1'b0; dn.dat_r = 32'hBAD0_0000;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (done || n == abort_cyc) begin
        up.cyc = 1'b0; up.stb = 1'b0;
      end
      dn.ack   = (n == ack_cyc);
      dn.dat_r = (n == ack_cyc) ? sdata : (32'hBAD0_0000 | 32'(n));
      if (n == 1) begin
        r_adr1 = dn.adr; r_wdat1 = dn.dat_w; r_we1 = dn.we; r_sel1 = dn.sel;
      end
      if (abort_cyc > 0 && n == abort_cyc + 1) r_cyc_after_abort = dn.cyc;
      if (dn.stb) begin
        r_stb_n++;
        if (r_stb_first < 0) r_stb_first = n;
        r_stb_last = n;
      end
      if (up.ack) begin
        r_ack_n++;
        if (r_first_ack < 0) r_first_ack = n;
        r_rdata = up.dat_r;
        r_irq_at_ack = timeout_irq;
        done = 1'b1;
      end
      if (timeout_irq) r_irq_n++;
    end
    up.cyc = 1'b0; up.stb = 1'b0; dn.ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({up.ack, dn.cyc, dn.stb, timeout_irq} !== 4'b0000)
      $display("FAIL rst_ctrl: got %b want 0000", {up.ack, dn.cyc, dn.stb, timeout_irq});
    else pass_cnt++;
    total_cnt++;
    if (up.dat_r !== 32'h0 || dn.adr !== 32'h0)
      $display("FAIL rst_data: dat %h adr %h want 0 0", up.dat_r, dn.adr);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dn.cyc !== 1'b0) $display("FAIL rst_idle_cyc: got %b want 0", dn.cyc);
    else pass_cnt++;
  endtask

  task automatic test_write();
    run_txn(1'b1, 4'hF, 32'h3004_0010, 32'hA5A5_0001, 2, 32'h0, 0, 6);
    total_cnt++;
    if (r_adr1 !== 32'h3004_0010 || r_wdat1 !== 32'hA5A5_0001 || r_we1 !== 1'b1 || r_sel1 !== 4'hF)
      $display("FAIL wr_fwd: adr %h dat %h we %b sel %h want 30040010 a5a50001 1 f",
               r_adr1, r_wdat1, r_we1, r_sel1);
    else pass_cnt++;
    total_cnt++;
    if (r_stb_first !== 1 || r_stb_last !== 2)
      $display("FAIL wr_stb_window: got %0d..%0d want 1..2", r_stb_first, r_stb_last);
    else pass_cnt++;
    total_cnt++;
    if (r_first_ack !== 3 || r_ack_n !== 1)
      $display("FAIL wr_ack: first %0d count %0d want 3 1", r_first_ack, r_ack_n);
    else pass_cnt++;
    total_cnt++;
    if (r_irq_n !== 0) $display("FAIL wr_irq: got %0d want 0", r_irq_n);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 4'hF, 32'h300D_0000, 32'h0, 0, 32'h0, 0, 22);
    total_cnt++;
    if (r_stb_first !== 1 || r_stb_last !== 16 || r_stb_n !== 16)
      $display("FAIL to_stb_window: got %0d..%0d n=%0d want 1..16 n=16",
               r_stb_first, r_stb_last, r_stb_n);
    else pass_cnt++;
    total_cnt++;
    if (r_first_ack !== 17 || r_ack_n !== 1)
      $display("FAIL to_ack: first %0d count %0d want 17 1", r_first_ack, r_ack_n);
    else pass_cnt++;
    total_cnt++;
    if (r_irq_n !== 1 || r_irq_at_ack !== 1'b1)
      $display("FAIL to_irq: count %0d at_ack %b want 1 1", r_irq_n, r_irq_at_ack);
    else pass_cnt++;
    total_cnt++;
    if (r_rdata !== 32'hDEADBEEF) $display("FAIL to_data: got %h want deadbeef", r_rdata);
    else pass_cnt++;
  endtask

  task automatic test_ack_at_limit();
    run_txn(1'b0, 4'hF, 32'h3000_0100, 32'h0, 16, 32'h1234_5678, 0, 22);
    total_cnt++;
    if (r_first_ack !== 17 || r_ack_n !== 1)
      $display("FAIL lim_ack: first %0d count %0d want 17 1", r_first_ack, r_ack_n);
    else pass_cnt++;
    total_cnt++;
    if (r_rdata !== 32'h1234_5678) $display("FAIL lim_data: got %h want 12345678", r_rdata);
    else pass_cnt++;
    total_cnt++;
    if (r_irq_n !== 0) $display("FAIL lim_irq: got %0d want 0", r_irq_n);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (up.dat_r !== 32'h1234_5678) $display("FAIL lim_hold: got %h want 12345678", up.dat_r);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    run_txn(1'b0, 4'h3, 32'h3000_0200, 32'h0, 7, 32'h5555_AAAA, 5, 12);
    total_cnt++;
    if (r_cyc_after_abort !== 1'b0 || r_stb_last !== 5)
      $display("FAIL ab_drop: cyc@6 %b stb_last %0d want 0 5", r_cyc_after_abort, r_stb_last);
    else pass_cnt++;
    total_cnt++;
    if (r_ack_n !== 0 || r_irq_n !== 0)
      $display("FAIL ab_noack: ack %0d irq %0d want 0 0", r_ack_n, r_irq_n);
    else pass_cnt++;
    run_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 3, 32'hC0FF_EE01, 0, 8);
    total_cnt++;
    if (r_first_ack !== 4 || r_ack_n !== 1 || r_rdata !== 32'hC0FF_EE01)
      $display("FAIL ab_next: first %0d count %0d data %h want 4 1 c0ffee01",
               r_first_ack, r_ack_n, r_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    up.cyc = 1'b1; up.stb = 1'b1; up.we = 1'b0; up.sel = 4'hF;
    up.adr = 32'h3000_1000; dn.ack = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (dn.stb !== 1'b1) $display("FAIL rm_busy: stb %b want 1", dn.stb);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({up.ack, dn.cyc, dn.stb, timeout_irq} !== 4'b0000 || dn.adr !== 32'h0 || up.dat_r !== 32'h0)
      $display("FAIL rm_clear: ctrl %b adr %h dat %h want 0000 0 0",
               {up.ack, dn.cyc, dn.stb, timeout_irq}, dn.adr, up.dat_r);
    else pass_cnt++;
    rst = 1'b0; up.cyc = 1'b0; up.stb = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 4'hF, 32'h3004_0010, 32'hA5A5_0001, 2, 32'h0, 0, 6);
    total_cnt++;
    if (r_first_ack !== 3 || r_adr1 !== 32'h3004_0010 || r_irq_n !== 0)
      $display("FAIL rm_after: ack %0d adr %h irq %0d want 3 30040010 0",
               r_first_ack, r_adr1, r_irq_n);
    else pass_cnt++;
  endtask

`ifdef WB_TIMEOUT_STATS_EN
  task automatic test_stats();
    total_cnt++;
    if (to_count !== 16'd0) $display("FAIL st_init: got %0d want 0", to_count);
    else pass_cnt++;
    run_txn(1'b0, 4'hF, 32'h300E_0000, 32'h0, 0, 32'h0, 0, 20);
    total_cnt++;
    if (to_count !== 16'd1 || to_addr !== 32'h300E_0000)
      $display("FAIL st_first: count %0d addr %h want 1 300e0000", to_count, to_addr);
    else pass_cnt++;
    run_txn(1'b1, 4'hF, 32'h300F_0004, 32'h1, 0, 32'h0, 0, 20);
    total_cnt++;
    if (to_count !== 16'd2 || to_addr !== 32'h300F_0004)
      $display("FAIL st_second: count %0d addr %h want 2 300f0004", to_count, to_addr);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    up.cyc = 1'b0; up.stb = 1'b0; up.we = 1'b0; up.sel = '0;
    up.adr = '0; up.dat_w = '0;
    dn.ack = 1'b0; dn.dat_r = '0;
    test_reset();
    test_write();
    test_timeout();
    test_ack_at_limit();
    test_abort();
    test_reset_mid();
`ifdef WB_TIMEOUT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
